// File: rtl/execute_result_queue.sv
// -----------------------------------------------------------------------------
// execute_result_queue
//
// Small in-order FIFO between the execute stage and the memory stage. Each
// entry carries an execute result, its destination register index and a
// write-back enable. The queue also offers a combinational forwarding lookup
// over its registered contents so that later instructions can pick up a
// result that has not yet reached the register file.
//
// Ports
//   clk_i                  single clock, all state updates on the rising edge
//   rst_i                  synchronous active-high reset (beats flush and push/pop)
//   flush_i                drop every queued entry (mispredict / trap)
//   valid_i / ready_o      execute-side handshake (ready_o = not full)
//   result_i/rd_i/wb_en_i  incoming entry fields
//   valid_o / ready_i      memory-side handshake (valid_o = not empty)
//   result_o/rd_o/wb_en_o  head entry fields, forced to zero while empty
//   count_o                current occupancy, 0..DEPTH
//   fwd_rs_i               source register to look up
//   fwd_hit_o/fwd_data_o   youngest matching queued result, or zero
// -----------------------------------------------------------------------------
module execute_result_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [31:0]                result_i,
    input  logic [4:0]                 rd_i,
    input  logic                       wb_en_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [31:0]                result_o,
    output logic [4:0]                 rd_o,
    output logic                       wb_en_o,
    output logic [$clog2(DEPTH):0]     count_o,
    input  logic [4:0]                 fwd_rs_i,
    output logic                       fwd_hit_o,
    output logic [31:0]                fwd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Entry storage; deliberately not reset, occupancy decides what is live.
    logic [31:0] result_mem [DEPTH];
    logic [4:0]  rd_mem     [DEPTH];
    logic        wb_en_mem  [DEPTH];

    logic [PTR_W-1:0] head_q,  head_d;
    logic [PTR_W-1:0] tail_q,  tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] fwd_idx_s;

    // Handshake flags depend on registered occupancy only, so ready_o never
    // looks at ready_i (no pop-through when full).
    assign ready_o = (count_q != CNT_FULL);
    assign valid_o = (count_q != CNT_ZERO);
    assign count_o = count_q;

    assign push_s = valid_i && ready_o && !flush_i;
    assign pop_s  = valid_o && ready_i && !flush_i;

    // Next-state for pointers and occupancy; flush empties the queue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = PTR_ZERO;
            tail_d  = PTR_ZERO;
            count_d = CNT_ZERO;
        end else begin
            // Power-of-two depth: pointer increment wraps DEPTH-1 -> 0 for free.
            if (push_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset taking top priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= PTR_ZERO;
            tail_q  <= PTR_ZERO;
            count_q <= CNT_ZERO;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage write at the tail slot on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            result_mem[tail_q] <= result_i;
            rd_mem[tail_q]     <= rd_i;
            wb_en_mem[tail_q]  <= wb_en_i;
        end
    end

    // Head presentation: registered head entry, zeroed while the queue is empty.
    always_comb begin
        result_o = 32'd0;
        rd_o     = 5'd0;
        wb_en_o  = 1'b0;
        if (valid_o) begin
            result_o = result_mem[head_q];
            rd_o     = rd_mem[head_q];
            wb_en_o  = wb_en_mem[head_q];
        end else begin
            result_o = 32'd0;
            rd_o     = 5'd0;
            wb_en_o  = 1'b0;
        end
    end

    // Forwarding search from oldest to youngest so the last match (youngest)
    // wins. Only registered entries are visited, so the beat being pushed
    // this cycle is invisible while the head being popped is still found.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = 32'd0;
        fwd_idx_s  = PTR_ZERO;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && wb_en_mem[fwd_idx_s] &&
                (rd_mem[fwd_idx_s] == fwd_rs_i) && (fwd_rs_i != 5'd0)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = result_mem[fwd_idx_s];
            end else begin
                fwd_hit_o  = fwd_hit_o;
                fwd_data_o = fwd_data_o;
            end
        end
    end

endmodule
